// File: rtl/regfile_pkg.sv
// Shared register-file constants and the registered writeback record used by the
// writeback arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last grant;
// the pointer moves only when the caller reports that the grant was taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] last_q, last_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        last_d     = PtrW'(idx);
      end
    end
  end

  // Pointing at the last slot makes requester 0 the first one searched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PtrW'(NREQ - 1);
    end else if (advance) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle, registers the register-file write
// and forwards the in-flight write onto the read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]  req_rd,
  input  logic [NREQ-1:0][XLEN-1:0]        req_data,
  input  logic                             wb_stall,
  output logic                             reg_write,
  output logic [REG_ADDR_W-1:0]            rd,
  output logic [XLEN-1:0]                  data,
  input  logic [REG_ADDR_W-1:0]            rs1,
  input  logic [REG_ADDR_W-1:0]            rs2,
  input  logic [XLEN-1:0]                  rf_rd1,
  input  logic [XLEN-1:0]                  rf_rd2,
  output logic [XLEN-1:0]                  rd1,
  output logic [XLEN-1:0]                  rd2,
  output logic [CNT_W-1:0]                 contention_cnt
);

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       grant;
  logic                  advance;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  wb_t                   wb_q, wb_d;
  logic                  multi_valid;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign arb_req   = (reset || wb_stall) ? '0 : req_valid;
  assign advance   = |grant;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd | req_rd[i];
        sel_data = sel_data | req_data[i];
      end
    end
  end

  // A granted write to x0 is consumed but never reaches the register file.
  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    if (advance) begin
      wb_d.we   = (sel_rd != '0);
      wb_d.rd   = sel_rd;
      wb_d.data = sel_data;
    end
  end

  always_comb begin
    int unsigned nvalid;
    nvalid = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) nvalid = nvalid + 1;
    end
    multi_valid = (nvalid >= 2);
    cnt_d = (multi_valid && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign reg_write      = wb_q.we;
  assign rd             = wb_q.rd;
  assign data           = wb_q.data;
  assign contention_cnt = cnt_q;

  assign rd1 = (wb_q.we && (rs1 == wb_q.rd) && (rs1 != '0)) ? wb_q.data : rf_rd1;
  assign rd2 = (wb_q.we && (rs2 == wb_q.rd) && (rs2 != '0)) ? wb_q.data : rf_rd2;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of writeback requesters; index 0 = ALU, 1 = LSU.
REQ-002 Parameter CNT_W, default 16, width of the contention counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester writeback request.
REQ-006 req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high at a rising edge.
REQ-007 req_rd  input  NREQ x 5  destination register index per requester.
REQ-008 req_data  input  NREQ x 32  write data per requester.
REQ-009 wb_stall  input  1  when high, no request is granted.
REQ-010 reg_write  output  1  register file write enable.
REQ-011 rd  output  5  register file write index.
REQ-012 data  output  32  register file write data.
REQ-013 rs1, rs2  input  5 each  read indices, passed to the register file unchanged.
REQ-014 rf_rd1, rf_rd2  input  32 each  raw register file read data.
REQ-015 rd1, rd2  output  32 each  read data with in-flight write forwarded.
REQ-016 contention_cnt  output  CNT_W  number of cycles with more than one request valid.

Function
REQ-017 At most one requester SHALL be granted per cycle; req_ready is combinational from req_valid, wb_stall and the priority pointer.
REQ-018 Arbitration SHALL be round-robin: the search starts at the index after the last granted requester and wraps from NREQ-1 to 0.
REQ-019 The priority pointer SHALL update only on an accepted transfer, to the granted index.
REQ-020 wb_stall high SHALL force req_ready to all-zero; the pointer and output registers SHALL hold.
REQ-021 An accepted transfer at edge N SHALL drive reg_write=1, rd=req_rd, data=req_data for cycle N+1 (1-cycle latency, registered outputs).
REQ-022 An accepted transfer with req_rd=0 SHALL be consumed with reg_write=0 in cycle N+1 (x0 writes dropped).
REQ-023 With no accepted transfer at edge N, reg_write SHALL be 0 in cycle N+1; rd and data SHALL hold their previous values.
REQ-024 Forwarding is combinational: rd1 = data when reg_write=1, rs1=rd and rs1!=0; otherwise rd1 = rf_rd1. rd2 is formed the same way from rs2 and rf_rd2.
REQ-025 A read of index 0 SHALL always return rf_rd1 / rf_rd2 unmodified.
REQ-026 A requester with valid high and ready low SHALL keep rd and data stable; the block does not check this, and violating it is a requester error.
REQ-027 contention_cnt SHALL increment by 1 each cycle in which two or more req_valid bits are high, independent of wb_stall, and SHALL saturate at all-ones.
REQ-028 Two requesters targeting the same rd in consecutive cycles SHALL be written in grant order; the later write wins.

Reset
REQ-029 Reset asserted SHALL immediately force reg_write=0, rd=0, data=0, contention_cnt=0, and set the pointer so that requester 0 has highest priority.
REQ-030 Reset mid-transfer SHALL discard the registered write; nothing is written after reset deasserts.
REQ-031 req_ready SHALL be all-zero while reset is high.

Structure
REQ-032 The shared package regfile_pkg SHALL hold the constants REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the requester-index constants REQ_ALU=0 and REQ_LSU=1.
REQ-033 Arbitration SHALL be implemented as one sub-module, rr_arbiter, with inputs (clk, reset, req, advance) and output one-hot grant.
REQ-034 The register file itself SHALL be instantiated outside this block.

Verification
REQ-035 Only req_valid[0] is held high with rd=5, data=0xDEADBEEF -> req_ready[0]=1 in the same cycle; the next cycle shows reg_write=1, rd=5, data=0xDEADBEEF.
REQ-036 Both requesters are valid for 4 cycles after reset -> grants are 0,1,0,1 and contention_cnt=4.
REQ-037 Requester 1 is valid with rd=0, data=0x1234 -> it is accepted, and reg_write stays 0 in the next cycle.
REQ-038 A write of rd=7, data=0xA5A5A5A5 is in flight with rs1=7 and rf_rd1=0 -> rd1=0xA5A5A5A5; with rs2=0 and rf_rd2=0 -> rd2=0.
REQ-039 wb_stall=1 for 3 cycles with both requesters valid -> no grants, reg_write=0, pointer unchanged; after release, the grant goes to the requester next in round-robin order.
REQ-040 Reset is asserted in the cycle reg_write=1 -> reg_write=0, rd=0, data=0 immediately, with no write visible afterwards.
